// File: rtl/reg_deslocamento_seq.sv
// reg_deslocamento_seq
// Sequential shift register for the multicycle datapath. It takes the operand
// from mux_Sl_Sr and shifts or rotates it by a programmable amount, moving one
// bit position per clock. The result goes to the register-file write-data mux.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset; clears all state
//   entrada    operand (DATA_W bits), captured when an operation is accepted
//   n          shift amount (SHAMT_W bits), captured together with start
//   shift_op   operation: 000 nop, 001 load, 010 SLL, 011 SRL, 100 SRA,
//              101 ROR, 110 ROL, 111 reserved (nop)
//   start      request; only accepted in IDLE
//   busy       registered, high in SHIFT and DONE
//   done       registered, one-cycle pulse in DONE (saida is final)
//   saida      shift register contents
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: start is a single-cycle request sampled only in IDLE. The
// controller waits for done, which is high for exactly one cycle. A start seen
// in SHIFT or DONE is dropped. The next request can be accepted in the first
// IDLE cycle after DONE.
module reg_deslocamento_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  entrada,
  input  logic [SHAMT_W-1:0] n,
  input  logic [2:0]         shift_op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  saida,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  state_t             state, state_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  saida_d;
  logic [DATA_W-1:0]  step;
  logic               is_shift;

  assign is_shift  = (shift_op >= OP_SLL) && (shift_op <= OP_ROL);
  assign state_dbg = state;

  // One-position move of the current contents according to the latched op.
  // Amounts of DATA_W or more need no special handling: repeated single steps
  // saturate the logical shifts and wrap the rotates.
  always_comb begin
    step = saida;
    case (op_q)
      OP_SLL:  step = {saida[DATA_W-2:0], 1'b0};
      OP_SRL:  step = {1'b0, saida[DATA_W-1:1]};
      OP_SRA:  step = {saida[DATA_W-1], saida[DATA_W-1:1]};
      OP_ROR:  step = {saida[0], saida[DATA_W-1:1]};
      OP_ROL:  step = {saida[DATA_W-2:0], saida[DATA_W-1]};
      default: step = saida;
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = op_q;
    saida_d = saida;
    case (state)
      IDLE: begin
        if (start) begin
          if (shift_op == OP_LOAD) begin
            saida_d = entrada;
            state_d = DONE;
          end else if (is_shift) begin
            saida_d = entrada;
            op_d    = shift_op;
            cnt_d   = n;
            state_d = (n == '0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        saida_d = step;
        cnt_d   = cnt - 1'b1;
        if (cnt == SHAMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so neither depends
  // combinationally on start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      saida <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
      saida <= saida_d;
      busy  <= (state_d != IDLE);
      done  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_reg_deslocamento_seq.sv
module tb_reg_deslocamento_seq;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               reset;
  logic [DATA_W-1:0]  entrada;
  logic [SHAMT_W-1:0] n;
  logic [2:0]         shift_op;
  logic               start;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  saida;
  logic [1:0]         state_dbg;

  int checks   = 0;
  int failures = 0;

  reg_deslocamento_seq #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .entrada   (entrada),
    .n         (n),
    .shift_op  (shift_op),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .saida     (saida),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0]  ent;
    logic [SHAMT_W-1:0] amt;
    logic [2:0]         op;
    logic [DATA_W-1:0]  exp_saida;
    int                 exp_lat;   // negedges after the start edge until done; 0 = no done
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for exactly one edge, then watch a bounded window.
  task automatic run_op(input vec_t v, input string name);
    int lat, busy_cnt, done_cnt;
    lat = 0; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    entrada  = v.ent;
    n        = v.amt;
    shift_op = v.op;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    entrada  = $urandom;
    n        = SHAMT_W'($urandom_range(0, 31));
    for (int k = 1; k <= v.exp_lat + 4; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
    end
    chk({name, " latency"}, lat, v.exp_lat);
    chk({name, " busy_cycles"}, busy_cnt, v.exp_lat);
    chk({name, " done_pulses"}, done_cnt, (v.exp_lat == 0) ? 0 : 1);
    chk({name, " saida"}, saida, v.exp_saida);
    chk({name, " state_idle"}, 32'(state_dbg), 0);
  endtask

  initial begin
    vec_t v;
    int lat;
    reset = 1'b0; start = 1'b0; entrada = '0; n = '0; shift_op = '0;

    // {entrada, n, op, expected saida, expected latency}
    vecs.push_back('{32'h0000_0001, 5'd4,  3'b010, 32'h0000_0010, 5});
    vecs.push_back('{32'h8000_0000, 5'd31, 3'b100, 32'hFFFF_FFFF, 32});
    vecs.push_back('{32'h8000_0000, 5'd31, 3'b011, 32'h0000_0001, 32});
    vecs.push_back('{32'h0000_00F1, 5'd4,  3'b101, 32'h1000_000F, 5});
    vecs.push_back('{32'h8000_0001, 5'd1,  3'b110, 32'h0000_0003, 2});
    vecs.push_back('{32'hDEAD_BEEF, 5'd0,  3'b010, 32'hDEAD_BEEF, 1});
    vecs.push_back('{32'h4000_0000, 5'd3,  3'b100, 32'h0800_0000, 4});
    vecs.push_back('{32'h1234_5678, 5'd8,  3'b110, 32'h3456_7812, 9});
    vecs.push_back('{32'hFFFF_FFFF, 5'd31, 3'b010, 32'h8000_0000, 32});
    vecs.push_back('{32'h1234_5678, 5'd9,  3'b001, 32'h1234_5678, 1});
    vecs.push_back('{32'hCAFE_F00D, 5'd3,  3'b111, 32'h1234_5678, 0});
    vecs.push_back('{32'hCAFE_F00D, 5'd3,  3'b000, 32'h1234_5678, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset saida", saida, 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset state", 32'(state_dbg), 0);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held into DONE: second request must be dropped
    @(negedge clk);
    entrada = 32'hAAAA_0001; shift_op = 3'b001; start = 1'b1;
    @(posedge clk);
    #1 entrada = 32'h5555_0002;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done saida", saida, 32'hAAAA_0001);
    chk("start_in_done state", 32'(state_dbg), 0);
    chk("start_in_done done", 32'(done), 0);

    // start during SHIFT is ignored
    lat = 0;
    @(negedge clk);
    entrada = 32'hFFFF_FFFF; n = 5'd8; shift_op = 3'b011; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done && lat == 0) lat = k;
      if (k == 3) begin
        start = 1'b1; shift_op = 3'b010; entrada = 32'h0; n = 5'd2;
      end
      if (k == 4) start = 1'b0;
    end
    chk("ignore_start latency", lat, 9);
    chk("ignore_start saida", saida, 32'h00FF_FFFF);

    // reset in the middle of a shift
    @(negedge clk);
    entrada = 32'hFFFF_FFFF; n = 5'd8; shift_op = 3'b011; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset busy_before", 32'(busy), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset saida", saida, 0);
    chk("mid_reset busy", 32'(busy), 0);
    chk("mid_reset done", 32'(done), 0);
    chk("mid_reset state", 32'(state_dbg), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_reset quiet", 32'({busy, done}), 0);
    v = '{32'h0F0F_0000, 5'd4, 3'b011, 32'h00F0_F000, 5};
    run_op(v, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
